// File: rtl/i2c_eeprom_writer.sv
// Single-byte I2C EEPROM writer for 24xx1025-style parts (17-bit address).
// Each request sends START, control byte, address high/low, the data byte and
// STOP. It then ACK-polls with START, control byte and STOP until the device
// finishes its internal write cycle or the poll budget runs out.
// SCL and SDA are open-drain. Each bit is four quarter-period ticks long.
module i2c_eeprom_writer #(
  parameter int          CLK_DIV  = 8,
  parameter logic [1:0]  DEV_SEL  = 2'b00,
  parameter logic [15:0] MAX_POLL = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_req,
  input  logic [16:0] address,
  input  logic [7:0]  data,
  output logic        ready,
  output logic        error,
  output logic        busy,
  inout  wire         i2c_sda,
  inout  wire         i2c_scl
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_CTRL,
    S_ADDR_H,
    S_ADDR_L,
    S_DATA,
    S_STOP,
    S_POLL_START,
    S_POLL_CTRL,
    S_POLL_STOP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic        tick;       // one-cycle strobe, one per SCL quarter period
  logic [1:0]  qtr;        // quarter within the current bit or condition
  logic [3:0]  bit_cnt;    // 0..7 data bits, 8 = ACK slot
  logic [15:0] poll_cnt;   // NACKed poll attempts so far
  logic [16:0] addr_q;
  logic [7:0]  data_q;
  logic        sda_low;    // 1 pulls SDA to ground, 0 releases it
  logic        scl_low;
  logic [1:0]  sda_sync;
  logic        ack_n;      // SDA level sampled in the ACK slot, 1 = NACK
  logic        fail;       // a write-frame byte was NACKed
  logic        poll_ok;    // the last poll was ACKed

  logic [7:0]  ctrl_byte;
  logic [7:0]  tx_byte;
  logic        tx_bit;

  assign ctrl_byte = {4'b1010, DEV_SEL, addr_q[16], 1'b0};

  // Open-drain pads: only ever drive low, otherwise float to the pull-ups.
  assign i2c_sda = sda_low ? 1'b0 : 1'bz;
  assign i2c_scl = scl_low ? 1'b0 : 1'bz;

  // Select the byte being shifted out in the current frame state.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    tx_byte = 8'h00;
    case (state)
      S_CTRL, S_POLL_CTRL: tx_byte = ctrl_byte;
      S_ADDR_H:            tx_byte = addr_q[15:8];
      S_ADDR_L:            tx_byte = addr_q[7:0];
      S_DATA:              tx_byte = data_q;
      default:             tx_byte = 8'h00;
    endcase
  end

  // Pick the current bit MSB first. The ACK slot releases SDA.
  always_comb begin
    tx_bit = 1'b1;
    if (bit_cnt < 4'd8) tx_bit = tx_byte[3'd7 - bit_cnt[2:0]];
  end

  // Quarter-period divider. It is parked at zero while idle, so the first
  // tick of a request always comes CLK_DIV cycles after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples values from before the edge.
    if (rst) begin
      div_cnt <= 8'd0;
      tick    <= 1'b0;
    end else if (state == S_IDLE) begin
      div_cnt <= 8'd0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= 8'd0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 8'd1;
      tick    <= 1'b0;
    end
  end

  // Two-flop synchronizer for SDA, which is driven asynchronously by the slave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sda_sync <= 2'b11;
    else     sda_sync <= {sda_sync[0], i2c_sda};
  end

  // Protocol sequencer. Bus pins, ready, error and busy are all registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      qtr      <= 2'd0;
      bit_cnt  <= 4'd0;
      poll_cnt <= 16'd0;
      addr_q   <= 17'd0;
      data_q   <= 8'd0;
      sda_low  <= 1'b0;
      scl_low  <= 1'b0;
      ack_n    <= 1'b1;
      fail     <= 1'b0;
      poll_ok  <= 1'b0;
      ready    <= 1'b0;
      error    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ready <= 1'b0;
      error <= 1'b0;
      if (state == S_IDLE) begin
        sda_low <= 1'b0;
        scl_low <= 1'b0;
        qtr     <= 2'd0;
        bit_cnt <= 4'd0;
        // A request seen in the ready cycle belongs to the finished transfer,
        // so it is not accepted.
        if (write_req && !busy && !ready) begin
          addr_q   <= address;
          data_q   <= data;
          poll_cnt <= 16'd0;
          fail     <= 1'b0;
          poll_ok  <= 1'b0;
          busy     <= 1'b1;
          state    <= S_START;
        end
      end else if (tick) begin
        qtr <= qtr + 2'd1;
        case (state)
          S_START, S_POLL_START: begin
            case (qtr)
              2'd0: begin
                sda_low <= 1'b0;
                scl_low <= 1'b0;
              end
              2'd1: sda_low <= 1'b1;          // SDA falls while SCL is high
              2'd2: ;
              default: begin
                scl_low <= 1'b1;
                bit_cnt <= 4'd0;
                state   <= (state == S_START) ? S_CTRL : S_POLL_CTRL;
              end
            endcase
          end

          S_CTRL, S_ADDR_H, S_ADDR_L, S_DATA, S_POLL_CTRL: begin
            case (qtr)
              2'd0: begin
                scl_low <= 1'b1;
                sda_low <= ~tx_bit;
              end
              2'd1: scl_low <= 1'b0;
              2'd2: if (bit_cnt == 4'd8) ack_n <= sda_sync[1];
              default: begin
                scl_low <= 1'b1;
                if (bit_cnt != 4'd8) begin
                  bit_cnt <= bit_cnt + 4'd1;
                end else begin
                  bit_cnt <= 4'd0;
                  if (state == S_POLL_CTRL) begin
                    if (ack_n) poll_cnt <= poll_cnt + 16'd1;
                    else       poll_ok  <= 1'b1;
                    state <= S_POLL_STOP;
                  end else if (ack_n || state == S_DATA) begin
                    fail  <= ack_n;
                    state <= S_STOP;
                  end else if (state == S_CTRL) begin
                    state <= S_ADDR_H;
                  end else if (state == S_ADDR_H) begin
                    state <= S_ADDR_L;
                  end else begin
                    state <= S_DATA;
                  end
                end
              end
            endcase
          end

          S_STOP, S_POLL_STOP: begin
            case (qtr)
              2'd0: begin
                scl_low <= 1'b1;
                sda_low <= 1'b1;
              end
              2'd1: scl_low <= 1'b0;
              2'd2: sda_low <= 1'b0;          // SDA rises while SCL is high
              default: begin
                if (state == S_STOP && !fail) begin
                  state <= S_POLL_START;
                end else if (state == S_POLL_STOP && !poll_ok && poll_cnt < MAX_POLL) begin
                  state <= S_POLL_START;
                end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  ready <= 1'b1;
                  error <= fail || !poll_ok;
                end
              end
            endcase
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_writer.sv
// Self-checking bench for i2c_eeprom_writer. Two writers share one open-drain
// bus: dut_a uses the default poll budget and dut_b allows 3 polls. A behavioural
// EEPROM decodes the bus and ACKs or NACKs as each test configures it. Expected
// bus tokens and responses go into queues, and monitors compare against them.
`timescale 1ns/1ps
module tb_i2c_eeprom_writer;

  localparam int TOK_START = 256;
  localparam int TOK_STOP  = 257;

  typedef struct {
    bit which;   // 0 = dut_a, 1 = dut_b
    bit err;
    int lat;     // clk cycles from accept to ready, 0 = not checked
  } resp_t;

  logic        clk;
  logic        rst;
  logic        write_req_a, write_req_b;
  logic [16:0] address;
  logic [7:0]  data;
  logic        ready_a, error_a, busy_a;
  logic        ready_b, error_b, busy_b;
  wire         sda, scl;
  logic        model_sda_low;

  pullup (sda);
  pullup (scl);
  assign sda = model_sda_low ? 1'b0 : 1'bz;

  int    exp_bus[$];
  resp_t exp_resp[$];
  int    checks    = 0;
  int    errors    = 0;
  int    done_cnt  = 0;
  int    cyc       = 0;
  int    nack_byte = -1;   // byte index in the write frame to NACK, -1 = none
  int    nack_polls = 0;   // number of leading poll frames to NACK

  // Bus-model state
  logic       bm_psda, bm_pscl, bm_csda, bm_cscl, bm_pbusy, bm_cbusy;
  logic [7:0] bm_shreg;
  int         bm_bit_n, bm_frame_idx, bm_byte_idx;
  bit         bm_in_frame;
  // Response-monitor state
  logic       rm_pbusy;
  int         rm_accept_cyc;
  resp_t      rm_e;

  i2c_eeprom_writer #(.CLK_DIV(4), .DEV_SEL(2'b00)) dut_a (
    .clk(clk), .rst(rst), .write_req(write_req_a), .address(address), .data(data),
    .ready(ready_a), .error(error_a), .busy(busy_a), .i2c_sda(sda), .i2c_scl(scl)
  );

  i2c_eeprom_writer #(.CLK_DIV(4), .DEV_SEL(2'b00), .MAX_POLL(16'd3)) dut_b (
    .clk(clk), .rst(rst), .write_req(write_req_b), .address(address), .data(data),
    .ready(ready_b), .error(error_b), .busy(busy_b), .i2c_sda(sda), .i2c_scl(scl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic push_write(input int c, input int ah, input int al, input int d);
    exp_bus.push_back(TOK_START);
    exp_bus.push_back(c);
    exp_bus.push_back(ah);
    exp_bus.push_back(al);
    exp_bus.push_back(d);
    exp_bus.push_back(TOK_STOP);
  endtask

  task automatic push_poll(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      exp_bus.push_back(TOK_START);
      exp_bus.push_back(c);
      exp_bus.push_back(TOK_STOP);
    end
  endtask

  task automatic push_resp(input bit which, input bit err, input int lat);
    resp_t r;
    r.which = which;
    r.err   = err;
    r.lat   = lat;
    exp_resp.push_back(r);
  endtask

  task automatic log_token(input int tok);
    if (exp_bus.size() == 0) check("bus_unexpected_token", tok, -1);
    else                     check("bus_token", tok, exp_bus.pop_front());
  endtask

  function automatic bit ack_decision(input int frame, input int byte_i);
    if (frame <= 1) return (byte_i != nack_byte);
    return ((frame - 2) >= nack_polls);
  endfunction

  // EEPROM model and bus decoder. It samples on the falling clk edge.
  initial begin
    model_sda_low = 1'b0;
    bm_psda = 1'b1; bm_pscl = 1'b1; bm_pbusy = 1'b0;
    bm_bit_n = 0; bm_frame_idx = 0; bm_byte_idx = 0; bm_in_frame = 0; bm_shreg = 8'h00;
    forever begin
      @(negedge clk);
      bm_cbusy = busy_a | busy_b;
      if (rst) begin
        model_sda_low = 1'b0;
        bm_bit_n = 0; bm_frame_idx = 0; bm_byte_idx = 0; bm_in_frame = 0;
        bm_psda = 1'b1; bm_pscl = 1'b1; bm_pbusy = 1'b0;
      end else begin
        if (bm_cbusy && !bm_pbusy) bm_frame_idx = 0;
        bm_pbusy = bm_cbusy;
        bm_csda = sda;
        bm_cscl = scl;
        if (bm_pscl && bm_cscl && bm_psda && !bm_csda) begin
          log_token(TOK_START);
          bm_in_frame = 1; bm_bit_n = 0; bm_byte_idx = 0;
          bm_frame_idx++;
        end else if (bm_pscl && bm_cscl && !bm_psda && bm_csda) begin
          log_token(TOK_STOP);
          bm_in_frame = 0;
        end else if (bm_in_frame && !bm_pscl && bm_cscl) begin
          if (bm_bit_n < 8) begin
            bm_shreg = {bm_shreg[6:0], bm_csda};
            bm_bit_n++;
            if (bm_bit_n == 8) log_token(int'(bm_shreg));
          end else begin
            bm_bit_n++;
          end
        end else if (bm_in_frame && bm_pscl && !bm_cscl) begin
          if (bm_bit_n == 8) begin
            model_sda_low = ack_decision(bm_frame_idx, bm_byte_idx);
          end else if (bm_bit_n == 9) begin
            model_sda_low = 1'b0;
            bm_bit_n = 0;
            bm_byte_idx++;
          end
        end
        bm_psda = bm_csda;
        bm_pscl = bm_cscl;
      end
    end
  end

  // Response monitor: accept time, then ready/error against the queue.
  initial begin
    rm_pbusy = 1'b0;
    rm_accept_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rm_pbusy = 1'b0;
      end else begin
        if ((busy_a | busy_b) && !rm_pbusy) rm_accept_cyc = cyc;
        rm_pbusy = busy_a | busy_b;
        if (ready_a || ready_b) begin
          if (exp_resp.size() == 0) begin
            check("ready_unexpected", 1, 0);
          end else begin
            rm_e = exp_resp.pop_front();
            check("ready_source", int'(ready_b), int'(rm_e.which));
            check("error_flag", rm_e.which ? int'(error_b) : int'(error_a), int'(rm_e.err));
            check("busy_at_ready", int'(busy_a | busy_b), 0);
            if (rm_e.lat != 0) check("latency", cyc - rm_accept_cyc, rm_e.lat);
          end
          done_cnt++;
        end
        if ((error_a && !ready_a) || (error_b && !ready_b)) check("error_without_ready", 1, 0);
      end
    end
  end

  // Drive one request. Address and data are scrambled after acceptance.
  task automatic start_req(input bit which, input logic [16:0] a, input logic [7:0] d,
                           input bit release_rst, input bit hold);
    @(posedge clk); #2;
    if (release_rst) rst = 1'b0;
    address = a;
    data    = d;
    if (which) write_req_b = 1'b1;
    else       write_req_a = 1'b1;
    @(posedge clk); #2;
    check("accept_busy", which ? int'(busy_b) : int'(busy_a), 1);
    if (!hold) begin
      write_req_a = 1'b0;
      write_req_b = 1'b0;
    end
    address = ~a;
    data    = ~d;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) check("wait_done_timeout", done_cnt, target);
  endtask

  int tgt, n, d0;
  bit seen_busy;

  initial begin
    rst = 1'b1;
    write_req_a = 1'b0;
    write_req_b = 1'b0;
    address = 17'd0;
    data = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_busy_b", int'(busy_b), 0);
    check("rst_ready_a", int'(ready_a), 0);
    check("rst_ready_b", int'(ready_b), 0);
    check("rst_error_a", int'(error_a), 0);
    check("rst_error_b", int'(error_b), 0);
    check("rst_sda_released", int'(sda), 1);
    check("rst_scl_released", int'(scl), 1);

    // Basic write, accepted on the first edge after reset, polled once.
    nack_byte = -1; nack_polls = 0;
    push_write(8'hA2, 8'h23, 8'h45, 8'hA5);
    push_poll(8'hA2, 1);
    push_resp(0, 0, 785);
    tgt = done_cnt + 1;
    start_req(0, 17'h1_2345, 8'hA5, 1, 0);
    wait_done(tgt, 3000);
    check("bus_drained_basic", exp_bus.size(), 0);

    // The first three polls are NACKed, so four poll frames are sent.
    nack_byte = -1; nack_polls = 3;
    push_write(8'hA0, 8'h00, 8'h10, 8'h3C);
    push_poll(8'hA0, 4);
    push_resp(0, 0, 1313);
    tgt = done_cnt + 1;
    start_req(0, 17'h0_0010, 8'h3C, 0, 0);
    wait_done(tgt, 4000);
    check("bus_drained_poll4", exp_bus.size(), 0);

    // ADDR_L is NACKed: STOP follows at once, with no data and no polls.
    nack_byte = 2; nack_polls = 0;
    exp_bus.push_back(TOK_START);
    exp_bus.push_back(8'hA2);
    exp_bus.push_back(8'hAB);
    exp_bus.push_back(8'hCD);
    exp_bus.push_back(TOK_STOP);
    push_resp(0, 1, 465);
    tgt = done_cnt + 1;
    start_req(0, 17'h1_ABCD, 8'h77, 0, 0);
    wait_done(tgt, 3000);
    check("bus_drained_nack_addr_l", exp_bus.size(), 0);

    // Polls are never ACKed; dut_b gives up after exactly 3 poll frames.
    nack_byte = -1; nack_polls = 1000;
    push_write(8'hA0, 8'h5A, 8'h5A, 8'h01);
    push_poll(8'hA0, 3);
    push_resp(1, 1, 1137);
    tgt = done_cnt + 1;
    start_req(1, 17'h0_5A5A, 8'h01, 0, 0);
    wait_done(tgt, 4000);
    check("bus_drained_poll_limit", exp_bus.size(), 0);

    // Reset during the DATA byte: the bus is released at once and no ready pulses.
    nack_byte = -1; nack_polls = 0;
    exp_bus.push_back(TOK_START);
    exp_bus.push_back(8'hA0);
    exp_bus.push_back(8'h13);
    exp_bus.push_back(8'h57);
    start_req(0, 17'h0_1357, 8'hC3, 0, 0);
    n = 0;
    while (exp_bus.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("abort_reached_addr_l", exp_bus.size(), 0);
    repeat (40) @(posedge clk);
    n = 0;
    @(posedge clk); #2;
    while (!(scl == 1'b0 && sda == 1'b0) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check("abort_window_found", int'(n < 200), 1);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("abort_sda_released", int'(sda), 1);
    check("abort_scl_released", int'(scl), 1);
    check("abort_busy_cleared", int'(busy_a), 0);
    check("abort_ready_low", int'(ready_a), 0);
    repeat (4) @(negedge clk);
    check("abort_no_ready", done_cnt, d0);

    // A new request straight after reset completes normally.
    push_write(8'hA2, 8'hFF, 8'hFF, 8'h00);
    push_poll(8'hA2, 1);
    push_resp(0, 0, 785);
    tgt = done_cnt + 1;
    start_req(0, 17'h1_FFFF, 8'h00, 1, 0);
    wait_done(tgt, 3000);
    check("bus_drained_after_reset", exp_bus.size(), 0);

    // write_req is held high through the transfer and the ready cycle.
    push_write(8'hA0, 8'h00, 8'h01, 8'hFF);
    push_poll(8'hA0, 1);
    push_resp(0, 0, 785);
    start_req(0, 17'h0_0001, 8'hFF, 0, 1);
    n = 0;
    @(negedge clk);
    while (!ready_a && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("held_ready_seen", int'(ready_a), 1);
    @(posedge clk); #2;
    write_req_a = 1'b0;
    seen_busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy_a) seen_busy = 1;
    end
    check("held_no_second_txn", int'(seen_busy), 0);
    check("bus_drained_held", exp_bus.size(), 0);

    repeat (50) @(negedge clk);
    check("resp_queue_empty", exp_resp.size(), 0);
    check("bus_queue_empty", exp_bus.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_writer.md
I2C_EEPROM_WRITER -- requirements
Module: i2c_eeprom_writer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8: clk cycles per SCL quarter-period, legal range 2..255.
REQ-002 SHALL have parameter DEV_SEL, default 2'b00: value of the A2:A1 chip-select bits in the control byte.
REQ-003 SHALL have parameter MAX_POLL, default 16'hFFFF: maximum number of ACK-poll attempts before error.
REQ-004 clk  input  1  sole clock; all flops on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 write_req  input  1  request; sampled only in IDLE.
REQ-007 address  input  17  EEPROM byte address; latched with write_req.
REQ-008 data  input  8  byte to write; latched with write_req.
REQ-009 ready  output  1  one-cycle pulse when the request is complete, whether it succeeded or failed.
REQ-010 error  output  1  one-cycle pulse, coincident with ready, on failure.
REQ-011 busy  output  1  high from the cycle after write_req is accepted until ready.
REQ-012 i2c_sda  inout  1  open-drain: drives 0 or Z only.
REQ-013 i2c_scl  inout  1  open-drain: drives 0 or Z only.

Function
REQ-014 A tick SHALL occur every CLK_DIV clk cycles while busy; the divider SHALL be held at 0 in IDLE.
REQ-015 Each bit SHALL take 4 ticks:
  - q0: SCL low, SDA set.
  - q1: SCL released.
  - q2: SDA sampled.
  - q3: SCL low.
REQ-016 START SHALL drive SDA low while SCL is high. STOP SHALL release SDA while SCL is high. Each condition SHALL last 4 ticks.
REQ-017 Bytes SHALL be sent MSB first. The 9th bit SHALL release SDA and sample the ACK (0 = ACK).
REQ-018 Control byte SHALL be {4'b1010, DEV_SEL, address[16], 1'b0}.
REQ-019 State sequence:
  - IDLE -> START -> CTRL -> ADDR_H (address[15:8]) -> ADDR_L (address[7:0]) -> DATA -> STOP -> POLL_START -> POLL_CTRL -> POLL_STOP -> IDLE.
REQ-020 A NACK in CTRL, ADDR_H, ADDR_L or DATA SHALL go to STOP and then IDLE with ready=1 and error=1. No EEPROM write is assumed in that case.
REQ-021 POLL_CTRL SHALL send the control byte.
  - On ACK: POLL_STOP, then IDLE with ready=1 and error=0.
  - On NACK: POLL_STOP, then POLL_START again.
REQ-022 The poll counter SHALL increment per NACK. Reaching MAX_POLL SHALL end with ready=1 and error=1.
REQ-023 write_req asserted while busy SHALL be ignored. It SHALL NOT be queued.
REQ-024 write_req held high in IDLE in the cycle ready pulses SHALL NOT start a new request. Acceptance SHALL require busy=0 and ready=0.
REQ-025 The latched address and data SHALL be stable for the whole transaction, independent of input changes.
REQ-026 Clock stretching is not supported; SCL SHALL NOT be sampled.
REQ-027 Minimum successful latency SHALL be (4 START + 4x36 bytes + 4 STOP + 4 START + 36 + 4 STOP) ticks = 196 ticks, plus 1 cycle.

Reset
REQ-028 On rst, every flop SHALL reset immediately without waiting for clk:
  - state=IDLE
  - SDA=Z, SCL=Z
  - ready=0, error=0, busy=0
  - divider, bit and poll counters = 0
REQ-029 rst mid-transaction SHALL abort with no STOP and no ready pulse. The bus SHALL be released in the same cycle.
REQ-030 The first request SHALL be accepted on the first clk edge after rst deasserts.

Verification
REQ-031 CLK_DIV=4, DEV_SEL=00, address=17'h1_2345, data=8'hA5, model ACKs everything and ACKs the first poll -> bus shows START A2 23 45 A5 STOP START A2 STOP; ready=1, error=0 exactly 785 clk after accept.
REQ-032 Model NACKs the first 3 polls -> 4 poll frames seen; ready=1, error=0 after the 4th.
REQ-033 Model NACKs ADDR_L -> STOP follows immediately; DATA is never sent; ready=1, error=1; no poll frames.
REQ-034 MAX_POLL=3, model never ACKs polls -> exactly 3 poll frames; ready=1, error=1.
REQ-035 rst pulsed during the DATA byte -> SDA and SCL are Z in the same cycle, no ready pulse; a new request after reset completes normally.
REQ-036 write_req held high across completion -> exactly one transaction; ready pulses once; busy returns to 0 for at least one cycle.
